// File: rtl/md_arb_pkg.sv
// -----------------------------------------------------------------------------
// md_arb_pkg
// Shared definitions for the data-memory access controller:
//   - default address / data widths
//   - configuration mode encodings driven on cfg_mode
//   - FSM state encoding of the access sequencer
//   - reset value of the process limit register (2^ADDR_W words)
// -----------------------------------------------------------------------------
package md_arb_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 32;

    // cfg_mode encodings; the fourth code (3) also holds the current config.
    localparam logic [1:0] MODE_HOLD   = 2'd0;
    localparam logic [1:0] MODE_KERNEL = 2'd1;
    localparam logic [1:0] MODE_PROC   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_CAPTURE = 2'd2
    } state_e;

    // Limit after reset covers the whole physical memory.
    function automatic int unsigned reset_limit(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

    localparam int unsigned RESET_LIMIT = reset_limit(ADDR_W_DEF);

endpackage

// File: rtl/md_addr_translate.sv
// -----------------------------------------------------------------------------
// md_addr_translate
// Combinational base relocation and limit check for the CPU port.
// Ports:
//   base      in  ADDR_W    relocation base (0 in kernel mode)
//   limit     in  ADDR_W+1  logical size in words of the current process
//   kernel    in  1         kernel mode: no limit check
//   addr      in  ADDR_W    logical address
//   phys_addr out ADDR_W    (base + addr) mod 2^ADDR_W
//   fault     out 1         addr outside the process limit
// -----------------------------------------------------------------------------
module md_addr_translate
    import md_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W:0]   limit,
    input  logic              kernel,
    input  logic [ADDR_W-1:0] addr,
    output logic [ADDR_W-1:0] phys_addr,
    output logic              fault
);

    always_comb begin
        // Sum truncates to ADDR_W bits: relocation wraps around silently.
        phys_addr = base + addr;
        // Zero-extend so a limit of 2^ADDR_W never faults.
        fault     = !kernel && ({1'b0, addr} >= limit);
    end

endmodule

// File: rtl/md_arbiter.sv
// -----------------------------------------------------------------------------
// md_arbiter
// Shares the synchronous data memory between the CPU port (0, relocated and
// limit-checked) and the loader/IO port (1, physical). Round-robin arbitration,
// one access at a time sequenced IDLE -> ACCESS (-> CAPTURE for reads).
// Ports:
//   clock, reset           clock, synchronous active-high reset
//   cfg_mode/base/limit    mode update (1 kernel, 2 process, 0/3 hold)
//   req*/we*/addr*/wdata*  per-port request, held until gnt*
//   gnt*                   one-cycle pulse when the access is issued
//   rvalid*, rdata         read data return (rdata shared, qualified by rvalid)
//   fault0                 limit violation pulse, coincident with gnt0
//   mem_addr/wdata/we      registered memory interface
//   mem_rdata              memory read data, one cycle after mem_addr
// -----------------------------------------------------------------------------
module md_arbiter
    import md_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        cfg_mode,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [ADDR_W:0]   cfg_limit,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              fault0,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [ADDR_W:0] LIMIT_RST = (ADDR_W + 1)'(reset_limit(ADDR_W));

    state_e            state;
    logic              kernel_mode;
    logic [ADDR_W-1:0] cur_base;
    logic [ADDR_W:0]   cur_limit;
    logic              last_grant;   // port granted most recently
    logic              lat_port;     // winner of the access in flight
    logic              lat_we;
    logic              lat_fault;

    logic [ADDR_W-1:0] phys0;
    logic              xlat_fault;
    logic              pick1;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_we;
    logic              sel_fault;

    // Translation always sees the registered config, so a config update in the
    // same cycle as a latched request does not affect that request.
    md_addr_translate #(.ADDR_W(ADDR_W)) u_xlat (
        .base      (cur_base),
        .limit     (cur_limit),
        .kernel    (kernel_mode),
        .addr      (addr0),
        .phys_addr (phys0),
        .fault     (xlat_fault)
    );

    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        pick1     = 1'b0;
        sel_addr  = phys0;
        sel_wdata = wdata0;
        sel_we    = we0;
        sel_fault = xlat_fault;
        // Port 1 wins when alone, or under contention when port 0 went last.
        if (req1 && (!req0 || !last_grant)) begin
            pick1     = 1'b1;
            sel_addr  = addr1;
            sel_wdata = wdata1;
            sel_we    = we1;
            sel_fault = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            kernel_mode <= 1'b1;
            cur_base    <= '0;
            cur_limit   <= LIMIT_RST;
            last_grant  <= 1'b1;
            lat_port    <= 1'b0;
            lat_we      <= 1'b0;
            lat_fault   <= 1'b0;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            rvalid0     <= 1'b0;
            rvalid1     <= 1'b0;
            fault0      <= 1'b0;
            rdata       <= '0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_we      <= 1'b0;
        end else begin
            case (cfg_mode)
                MODE_KERNEL: begin
                    kernel_mode <= 1'b1;
                    cur_base    <= '0;
                end
                MODE_PROC: begin
                    kernel_mode <= 1'b0;
                    cur_base    <= cfg_base;
                    cur_limit   <= cfg_limit;
                end
                default: ;  // MODE_HOLD and code 3 keep the current config
            endcase

            // Pulse outputs; only the state that raises them overrides.
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            fault0  <= 1'b0;
            mem_we  <= 1'b0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (req0 || req1) begin
                        lat_port   <= pick1;
                        lat_we     <= sel_we;
                        lat_fault  <= sel_fault;
                        last_grant <= pick1;
                        // Registered outputs become visible during ACCESS.
                        mem_addr   <= sel_addr;
                        mem_wdata  <= sel_wdata;
                        mem_we     <= sel_we && !sel_fault;
                        gnt0       <= !pick1;
                        gnt1       <= pick1;
                        fault0     <= sel_fault;
                        state      <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    state <= lat_we ? ST_IDLE : ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    rdata   <= lat_fault ? '0 : mem_rdata;
                    rvalid0 <= !lat_port;
                    rvalid1 <= lat_port;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_md_arbiter.sv
// -----------------------------------------------------------------------------
// tb_md_arbiter
// Self-checking bench for md_arbiter: a behavioural memory drives mem_rdata,
// a transaction-level reference model predicts grants, addresses, faults and
// read data; directed scenarios are followed by randomized traffic.
// -----------------------------------------------------------------------------
module tb_md_arbiter;
    import md_arb_pkg::*;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int MEM_WORDS = 1 << AW;

    logic          clock = 1'b0;
    logic          reset;
    logic [1:0]    cfg_mode;
    logic [AW-1:0] cfg_base;
    logic [AW:0]   cfg_limit;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1, fault0, mem_we;
    logic [DW-1:0] rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;

    int n_cmp = 0;
    int n_err = 0;

    md_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clock     (clock),
        .reset     (reset),
        .cfg_mode  (cfg_mode),
        .cfg_base  (cfg_base),
        .cfg_limit (cfg_limit),
        .req0      (req0),
        .req1      (req1),
        .we0       (we0),
        .we1       (we1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .rvalid0   (rvalid0),
        .rvalid1   (rvalid1),
        .rdata     (rdata),
        .fault0    (fault0),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
    );

    always #5 clock = ~clock;

    // Initial memory contents; word 0x010 carries a recognisable value.
    function automatic logic [31:0] pat(input int i);
        logic [31:0] v;
        if (i == 16) return 32'h1234_5678;
        v = 32'(i) * 32'h9E37_79B1;
        return v ^ 32'h5A5A_5A5A;
    endfunction

    // Synchronous memory seen by the DUT, self-initialised on the first edge.
    logic [31:0] mem [MEM_WORDS];
    bit          mem_ready = 1'b0;
    always @(posedge clock) begin
        if (!mem_ready) begin
            for (int i = 0; i < MEM_WORDS; i++) mem[i] <= pat(i);
            mem_ready <= 1'b1;
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        mem_rdata <= mem[mem_addr];
    end

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [MEM_WORDS];
    bit          m_kernel;
    int          m_base, m_limit, m_last;
    bit          pend [2];
    int          keep [2];
    bit          p_we [2];
    int          p_addr [2];
    logic [31:0] p_wdata [2];
    bit          cfg_pend;
    int          c_mode, c_base, c_limit;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_kernel = 1'b1;
        m_base   = 0;
        m_limit  = MEM_WORDS;
        m_last   = 1;
    endtask

    function automatic int phys_of(input int port, input int a);
        if (port == 1 || m_kernel) return a;
        return (m_base + a) % MEM_WORDS;
    endfunction

    function automatic bit fault_of(input int port, input int a);
        return (port == 0) && !m_kernel && (a >= m_limit);
    endfunction

    task automatic apply_cfg_model();
        if (c_mode == 1) begin
            m_kernel = 1'b1;
            m_base   = 0;
        end else if (c_mode == 2) begin
            m_kernel = 1'b0;
            m_base   = c_base;
            m_limit  = c_limit;
        end
        cfg_pend = 1'b0;
    endtask

    // Drive a config update; it lands at the coming clock edge.
    task automatic drive_cfg(input int mode, input int b, input int l);
        cfg_mode  = 2'(mode);
        cfg_base  = AW'(b);
        cfg_limit = (AW + 1)'(l);
        c_mode    = mode;
        c_base    = b;
        c_limit   = l;
        cfg_pend  = 1'b1;
    endtask

    task automatic set_cfg(input int mode, input int b, input int l);
        drive_cfg(mode, b, l);
        @(negedge clock);
        cfg_mode = MODE_HOLD;
        apply_cfg_model();
    endtask

    task automatic drive_req(input int port, input bit we, input int a, input logic [31:0] wd);
        pend[port]    = 1'b1;
        keep[port]    = 0;
        p_we[port]    = we;
        p_addr[port]  = a;
        p_wdata[port] = wd;
        if (port == 0) begin
            req0 = 1'b1; we0 = we; addr0 = AW'(a); wdata0 = wd;
        end else begin
            req1 = 1'b1; we1 = we; addr1 = AW'(a); wdata1 = wd;
        end
    endtask

    // Called at the falling edge of a cycle in which the DUT is idle; serves
    // every pending request and returns at the falling edge of an idle cycle.
    task automatic serve_all();
        int          w, ph;
        bit          ft, wr;
        logic [31:0] wd;
        while (pend[0] || pend[1]) begin
            if (pend[0] && pend[1]) w = (m_last == 1) ? 0 : 1;
            else                    w = pend[0] ? 0 : 1;
            m_last = w;
            wr = p_we[w];
            wd = p_wdata[w];
            ph = phys_of(w, p_addr[w]);
            ft = fault_of(w, p_addr[w]);
            // A config update sampled with this request applies afterwards.
            if (cfg_pend) apply_cfg_model();

            @(negedge clock);
            cfg_mode = MODE_HOLD;
            check("gnt0", gnt0, w == 0);
            check("gnt1", gnt1, w == 1);
            check("mem_addr", mem_addr, ph);
            check("mem_we", mem_we, wr && !ft);
            check("fault0", fault0, (w == 0) && ft);
            if (wr) check("mem_wdata", mem_wdata, wd);
            if (wr && !ft) ref_mem[ph] = wd;
            if (keep[w] > 0) keep[w]--;
            else begin
                pend[w] = 1'b0;
                if (w == 0) req0 = 1'b0; else req1 = 1'b0;
            end

            @(negedge clock);
            check("we_pulse_end", mem_we, 1'b0);
            check("gnt_pulse_end", gnt0 | gnt1, 1'b0);
            if (!wr) begin
                check("rvalid_early", rvalid0 | rvalid1, 1'b0);
                @(negedge clock);
                check("rvalid0", rvalid0, w == 0);
                check("rvalid1", rvalid1, w == 1);
                check("rdata", rdata, ft ? 32'h0 : ref_mem[ph]);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = pat(i);
        model_reset();
        pend[0] = 0; pend[1] = 0; keep[0] = 0; keep[1] = 0;
        cfg_pend = 0;
        reset = 1'b1;
        cfg_mode = MODE_HOLD; cfg_base = '0; cfg_limit = '0;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        repeat (3) @(negedge clock);

        // Reset values
        check("rst_gnt", {gnt0, gnt1}, 2'b00);
        check("rst_rvalid", {rvalid0, rvalid1}, 2'b00);
        check("rst_fault0", fault0, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_mem_addr", mem_addr, 12'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        reset = 1'b0;

        // Kernel read of the preloaded word
        drive_req(0, 1'b0, 'h010, 32'h0);
        serve_all();
        check("kernel_rdata_const", rdata, 32'h1234_5678);

        // Process-mode write, then read it back physically via port 1
        set_cfg(MODE_PROC, 'h800, 'h100);
        drive_req(0, 1'b1, 'h020, 32'hDEAD_BEEF);
        serve_all();
        drive_req(1, 1'b0, 'h820, 32'h0);
        serve_all();
        check("readback_const", rdata, 32'hDEAD_BEEF);

        // Limit faults: write at the limit, read above it
        drive_req(0, 1'b1, 'h100, 32'hCAFE_F00D);
        serve_all();
        drive_req(0, 1'b0, 'h150, 32'h0);
        serve_all();
        // Last word inside the limit
        drive_req(0, 1'b0, 'h0FF, 32'h0);
        serve_all();

        // Wrap-around
        set_cfg(MODE_PROC, 'hF00, 'h1000);
        drive_req(0, 1'b0, 'h180, 32'h0);
        serve_all();

        // Port 1 untranslated in process mode
        drive_req(1, 1'b0, 'h900, 32'h0);
        serve_all();

        // Both ports held continuously: grants alternate
        drive_req(0, 1'b0, 'h005, 32'h0);
        drive_req(1, 1'b1, 'h123, 32'h1111_2222);
        keep[0] = 3; keep[1] = 3;
        serve_all();

        // Config update in the same cycle as a latched request
        drive_cfg(MODE_KERNEL, 0, 0);
        drive_req(0, 1'b0, 'h200, 32'h0);
        serve_all();
        drive_req(0, 1'b0, 'h200, 32'h0);
        serve_all();

        // Reset during CAPTURE
        set_cfg(MODE_PROC, 'h400, 'h080);
        drive_req(0, 1'b0, 'h011, 32'h0);
        @(negedge clock);                 // ACCESS
        req0 = 1'b0; pend[0] = 1'b0;
        @(negedge clock);                 // CAPTURE
        reset = 1'b1;
        @(negedge clock);
        check("rst_mid_rvalid", {rvalid0, rvalid1}, 2'b00);
        check("rst_mid_gnt", {gnt0, gnt1}, 2'b00);
        check("rst_mid_mem_we", mem_we, 1'b0);
        check("rst_mid_rdata", rdata, 32'h0);
        reset = 1'b0;
        model_reset();
        drive_req(0, 1'b0, 'h123, 32'h0);   // kernel again: untranslated, no fault
        serve_all();

        // Contention from reset: port 0 first
        reset = 1'b1;
        drive_req(0, 1'b1, 'h040, 32'hA0A0_A0A0);
        drive_req(1, 1'b1, 'h041, 32'hB1B1_B1B1);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        model_reset();
        serve_all();

        // Randomized traffic
        for (int it = 0; it < 300; it++) begin
            int r, k;
            r = $urandom_range(0, 9);
            if (r == 0) begin
                set_cfg($urandom_range(0, 3), $urandom_range(0, MEM_WORDS - 1),
                        $urandom_range(0, 300));
            end else begin
                if (r == 1)
                    drive_cfg($urandom_range(0, 3), $urandom_range(0, MEM_WORDS - 1),
                              $urandom_range(0, 300));
                k = $urandom_range(1, 3);
                if (k[0]) drive_req(0, 1'($urandom_range(0, 1)), $urandom_range(0, 255), $urandom);
                if (k[1]) drive_req(1, 1'($urandom_range(0, 1)), $urandom_range(0, 255), $urandom);
                if (k == 3 && $urandom_range(0, 3) == 0) begin
                    keep[0] = $urandom_range(0, 2);
                    keep[1] = $urandom_range(0, 2);
                end
                serve_all();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
